// File: rtl/counter_updn.sv
`default_nettype none
// counter_updn: up/down step counter driven by a synchronised, edge-detected start input,
// with load, saturate or modulo wrap, and range flags.  Rev 1.0
module counter_updn #(
  parameter int WIDTH  = 5,
  parameter int MAXVAL = 19,
  parameter int STEP   = 1,
  parameter int WRAP   = 0
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             start,
  input  logic             ud,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped
);

  // One extra bit of headroom so state+STEP and state+MAXVAL+1 never overflow.
  localparam logic [WIDTH:0] c_MAX  = (WIDTH+1)'(MAXVAL);
  localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] c_MOD  = (WIDTH+1)'(MAXVAL + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_dly;
  logic [WIDTH-1:0] r_state;
  logic             r_wrapped;

  logic             w_step;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_up;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_unused;

  assign w_step   = r_sync2 & ~r_dly;
  assign w_cur    = {1'b0, r_state};
  assign w_up     = w_cur + c_STEP;
  assign w_unused = w_sum[WIDTH];

  always_comb begin
    w_sum  = '0;
    w_next = r_state;
    w_wrap = 1'b0;
    if (load) begin
      w_next = ({1'b0, load_val} > c_MAX) ? c_MAX[WIDTH-1:0] : load_val;
    end else if (w_step && enable) begin
      if (!ud) begin
        if (w_up > c_MAX) begin
          if (WRAP != 0) begin
            w_sum  = w_up - c_MOD;
            w_wrap = 1'b1;
          end else begin
            w_sum  = c_MAX;
          end
        end else begin
          w_sum = w_up;
        end
      end else begin
        if (w_cur >= c_STEP) begin
          w_sum = w_cur - c_STEP;
        end else if (WRAP != 0) begin
          w_sum  = w_cur + c_MOD - c_STEP;
          w_wrap = 1'b1;
        end else begin
          w_sum = '0;
        end
      end
      w_next = w_sum[WIDTH-1:0];
    end
  end

  // Clearing the synchroniser on reset both cancels a pending step and makes
  // a start held high through reset release look like a fresh rising edge.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_dly     <= 1'b0;
      r_state   <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_sync1   <= start;
      r_sync2   <= r_sync1;
      r_dly     <= r_sync2;
      r_state   <= w_next;
      r_wrapped <= w_wrap;
    end
  end

  assign state   = r_state;
  assign wrapped = r_wrapped;
  assign at_max  = (r_state == c_MAX[WIDTH-1:0]);
  assign at_min  = (r_state == '0);

endmodule
`default_nettype wire

// File: doc/counter_updn.md
COUNTER_UPDN -- requirements
Module: counter_updn

Interface
REQ-001 Parameter WIDTH, default 5: width of count value and load bus.
REQ-002 Parameter MAXVAL, default 19: top of count range; range is 0..MAXVAL; MAXVAL < 2**WIDTH.
REQ-003 Parameter STEP, default 1: increment/decrement per step event; legal 1..MAXVAL.
REQ-004 Parameter WRAP, default 0: 0 = saturate at range ends; 1 = modulo (MAXVAL+1) wrap-around.
REQ-005 mclk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  asynchronous step request (pushbutton-class); one step per rising edge.
REQ-008 ud  input  1  direction: 0 = count up, 1 = count down.
REQ-009 enable  input  1  1 = step events accepted; 0 = step events discarded.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value loaded when load=1.
REQ-012 state  output  WIDTH  current count, registered.
REQ-013 at_max  output  1  high while state == MAXVAL.
REQ-014 at_min  output  1  high while state == 0.
REQ-015 wrapped  output  1  one-cycle pulse after a wrap-around update.

Function
REQ-016 start SHALL pass through a 2-flop synchroniser then a third edge-detect flop; step event = sync_out & ~delayed.
REQ-017 start first sampled high at rising edge N SHALL update state at edge N+2; holding start high any length SHALL yield exactly one step.
REQ-018 A new step SHALL require start low for at least one sampling edge between highs.
REQ-019 ud and enable SHALL be sampled directly (unsynchronised) at the updating edge.
REQ-020 Up step, state <= MAXVAL-STEP: state += STEP.
REQ-021 Up step, state > MAXVAL-STEP: WRAP=0 -> state = MAXVAL; WRAP=1 -> state = state+STEP-(MAXVAL+1), wrapped pulses.
REQ-022 Down step, state >= STEP: state -= STEP.
REQ-023 Down step, state < STEP: WRAP=0 -> state = 0; WRAP=1 -> state = state+(MAXVAL+1)-STEP, wrapped pulses.
REQ-024 Boundary arithmetic SHALL use WIDTH+1-bit intermediates; no intermediate overflow for any legal parameter set.
REQ-025 Saturation SHALL never assert wrapped.
REQ-026 load=1 SHALL set state to load_val at the next edge; load_val > MAXVAL SHALL load MAXVAL.
REQ-027 load and step event in the same cycle: load wins, step discarded (not deferred).
REQ-028 enable=0 during a step event: event discarded, state unchanged; load still honoured.
REQ-029 wrapped SHALL be registered, high exactly the one cycle following the wrapping edge.
REQ-030 at_max/at_min SHALL be combinational decodes of the state register.

Reset
REQ-031 reset low SHALL immediately force state=0, wrapped=0, all synchroniser/edge flops=0, independent of mclk.
REQ-032 Reset asserted mid-synchronisation SHALL cancel any pending step.
REQ-033 If start is high when reset deasserts, it SHALL be treated as a rising edge: one step.

Verification (defaults unless stated)
REQ-034 reset, ud=0, 20 start pulses (1 cycle high, 1 low) -> state 1..19, then 19 held on 20th pulse; at_max=1, wrapped never high.
REQ-035 From 19, ud=1, 20 pulses -> 18..0, then 0 held; at_min=1 at end.
REQ-036 WRAP=1, STEP=3, load_val=18 load, ud=0 pulse -> state 1, wrapped one cycle; ud=1 pulse -> state 18, wrapped one cycle.
REQ-037 start held high 10 cycles -> exactly one increment, appearing at edge N+2.
REQ-038 load=1 load_val=25 coincident with step event -> state 19, no further step; enable=0 pulse -> state unchanged.
REQ-039 state=7, reset low between mclk edges during pending step -> state 0 immediately, no step after release.
